// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions for the encoder and reader paths.
// Pattern bit order is {a,b,c,d,e,f,g}, so segment a is the MSB.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Entry i holds the pattern for nibble i.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef struct packed {
    logic       legal;   // pattern is one of the 16 hex glyphs
    logic       blank;   // pattern is all segments off
    logic [3:0] nibble;  // valid only when legal
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] pat);
    seg_dec_t r;
    r = '0;
    r.blank = (pat == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TABLE[i]) begin
        r.legal  = 1'b1;
        r.nibble = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_reader_decode.sv
// seg_pattern_decode: combinational glyph decoder.
//   pat    : 7-bit {a..g} pattern
//   legal  : pattern is a hex glyph
//   blank  : pattern is all-off
//   nibble : decoded hex value (meaningful when legal)
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic             legal,
  output logic             blank,
  output logic [3:0]       nibble
);
  seg_dec_t dec;

  assign dec    = seg_decode(pat);
  assign legal  = dec.legal;
  assign blank  = dec.blank;
  assign nibble = dec.nibble;
endmodule

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: recovers per-digit nibbles from a multiplexed
// seven-segment bus, committing a digit only after STABLE_CNT identical
// samples.
//   clk, rst      : clock, synchronous active-high reset
//   a..g, an      : segment lines and one-hot digit enables
//   value, blank  : committed nibble / blank flag per digit
//   upd, upd_idx  : one-clock strobe + digit index on committed change
//   err_pat       : one-clock strobe, illegal pattern reached stability
//   err_an        : one-clock strobe, multi-hot an seen on a sample
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SAMPLE_DIV = 16,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  err_pat,
  output logic                  err_an
);
  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W   = $clog2(STABLE_CNT + 1);
  localparam int DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CNT);

  logic [DIV_W-1:0]                   div_q;
  logic                               tick;
  // Bus is registered every clock; the tick acts on this registered copy.
  logic [SEG_W-1:0]                   seg_q;
  logic [DIGITS-1:0]                  an_q;
  logic [DIGITS-1:0][SEG_W-1:0]       cand_q;
  logic [DIGITS-1:0][CNT_W-1:0]       cnt_q;
  logic [DIGITS-1:0][3:0]             value_q;

  logic [DIGIT_W-1:0] k;
  logic               an_one, an_multi;
  logic               same, sat, commit, changed;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               dec_legal, dec_blank;
  logic [3:0]         dec_nib;
  logic [3:0]         new_val;
  logic               new_blank;

  assign tick  = (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign value = value_q;

  seg_pattern_decode u_dec (
    .pat    (seg_q),
    .legal  (dec_legal),
    .blank  (dec_blank),
    .nibble (dec_nib)
  );

  always_comb begin
    k = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_q[i]) k = DIGIT_W'(i);
    end
    an_one   = (an_q != '0) && ((an_q & (an_q - DIGITS'(1))) == '0);
    an_multi = (an_q != '0) && !an_one;

    same    = (seg_q == cand_q[k]);
    sat     = (cnt_q[k] == CNT_SAT);
    nxt_cnt = same ? (sat ? cnt_q[k] : cnt_q[k] + CNT_W'(1)) : CNT_W'(1);
    // Commit only on the transition into saturation, not while parked there.
    commit  = tick && an_one && (nxt_cnt == CNT_SAT) && !(same && sat);

    new_val   = value_q[k];
    new_blank = blank[k];
    if (dec_legal) begin
      new_val   = dec_nib;
      new_blank = 1'b0;
    end else if (dec_blank) begin
      new_blank = 1'b1;
    end
    changed = commit && {new_blank, new_val} != {blank[k], value_q[k]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      blank   <= '1;
      upd     <= 1'b0;
      upd_idx <= '0;
      err_pat <= 1'b0;
      err_an  <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + DIV_W'(1);
      seg_q   <= {a, b, c, d, e, f, g};
      an_q    <= an;
      upd     <= 1'b0;
      err_pat <= 1'b0;
      err_an  <= 1'b0;
      if (tick && an_multi) begin
        err_an <= 1'b1;
      end else if (tick && an_one) begin
        cand_q[k] <= seg_q;
        cnt_q[k]  <= nxt_cnt;
        if (commit) begin
          value_q[k] <= new_val;
          blank[k]   <= new_blank;
          if (!dec_legal && !dec_blank) err_pat <= 1'b1;
          if (changed) begin
            upd     <= 1'b1;
            upd_idx <= 3'(k);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_reader.sv
module tb_seven_seg_reader;
  logic        clk, rst;
  logic        a, b, c, d, e, f, g;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        upd, err_pat, err_an;
  logic [2:0]  upd_idx;

  typedef struct { int idx; logic [3:0] nib; logic blnk; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int vectors = 0, miscompares = 0;
  int n_upd = 0, n_errpat = 0, n_erran = 0;
  int tdiv = 0;

  seven_seg_reader #(.DIGITS(4), .SAMPLE_DIV(16), .STABLE_CNT(3)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an(an), .value(value), .blank(blank), .upd(upd), .upd_idx(upd_idx),
    .err_pat(err_pat), .err_an(err_an)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference sample divider: 0..15, tick on 15.
  always @(posedge clk)
    if (rst) tdiv <= 0;
    else     tdiv <= (tdiv == 15) ? 0 : tdiv + 1;

  // Scoreboard consumer: every upd strobe pops one expected commit.
  always @(negedge clk) if (!rst) begin
    if (err_pat) n_errpat++;
    if (err_an)  n_erran++;
    if (int'(upd) + int'(err_pat) + int'(err_an) > 1) begin
      miscompares++;
      $display("FAIL strobe_exclusive upd=%0b err_pat=%0b err_an=%0b", upd, err_pat, err_an);
    end
    if (upd) begin
      n_upd++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL upd_unexpected got idx=%0d value=%h blank=%b, none expected", upd_idx, value, blank);
      end else begin
        mon_e = exp_q.pop_front();
        if (upd_idx !== 3'(mon_e.idx) || value[mon_e.idx*4 +: 4] !== mon_e.nib || blank[mon_e.idx] !== mon_e.blnk) begin
          miscompares++;
          $display("FAIL upd_scoreboard got idx=%0d nib=%h blank=%b, want idx=%0d nib=%h blank=%b",
                   upd_idx, value[mon_e.idx*4 +: 4], blank[mon_e.idx], mon_e.idx, mon_e.nib, mon_e.blnk);
        end
      end
    end
  end

  function automatic logic [6:0] pat_of(int n);
    case (n)
      1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;
      8: return 7'b1111111;  15: return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic set_bus(input logic [3:0] anv, input logic [6:0] p);
    {a, b, c, d, e, f, g} = p;
    an = anv;
  endtask

  // Returns 1ns after the n-th sampling edge from now.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      for (int guard = 0; guard < 40; guard++) begin
        @(posedge clk); #1;
        if (tdiv == 0) break;
      end
    end
  endtask

  task automatic push(input int idx, input logic [3:0] nib, input logic blnk);
    exp_t x;
    x.idx = idx; x.nib = nib; x.blnk = blnk;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1; set_bus(4'b0, 7'b0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    int base;
    do_reset();
    vectors++;
    if (value !== 16'h0 || blank !== 4'hF || upd !== 0 || err_pat !== 0 || err_an !== 0 || upd_idx !== 0) begin
      miscompares++;
      $display("FAIL reset_state got value=%h blank=%b upd=%b ep=%b ea=%b idx=%0d, want 0/1111/0/0/0/0",
               value, blank, upd, err_pat, err_an, upd_idx);
    end
    base = n_upd + n_errpat + n_erran;
    repeat (200) @(posedge clk);
    #1;
    vectors++;
    if (n_upd + n_errpat + n_erran !== base || value !== 16'h0 || blank !== 4'hF) begin
      miscompares++;
      $display("FAIL idle_bus strobes=%0d value=%h blank=%b, want 0 strobes, 0000, 1111",
               n_upd + n_errpat + n_erran - base, value, blank);
    end
  endtask

  task automatic test_single();
    int base;
    wait_ticks(1);
    base = n_upd;
    set_bus(4'b0001, pat_of(1));
    push(0, 4'h1, 1'b0);
    wait_ticks(2);
    vectors++;
    if (upd !== 1'b0) begin miscompares++; $display("FAIL single_early got upd=%b want 0", upd); end
    wait_ticks(1);
    vectors++;
    if (upd !== 1'b1 || upd_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL single_latency got upd=%b idx=%0d want upd=1 idx=0", upd, upd_idx);
    end
    wait_ticks(4);
    chk("single_value", {28'b0, value[3:0]}, 32'h1);
    chk("single_blank", {31'b0, blank[0]}, 32'h0);
    chk("single_no_more_upd", n_upd - base, 1);
    set_bus(4'b0, 7'b0);
  endtask

  task automatic test_roundrobin();
    int base;
    do_reset();
    wait_ticks(1);
    base = n_upd;
    for (int dgt = 0; dgt < 4; dgt++) push(dgt, 4'(dgt + 1), 1'b0);
    for (int t = 0; t < 20; t++) begin
      set_bus(4'(1 << (t % 4)), pat_of(t % 4 + 1));
      wait_ticks(1);
    end
    set_bus(4'b0, 7'b0);
    wait_ticks(1);
    chk("rr_value", {16'b0, value}, 32'h4321);
    chk("rr_blank", {28'b0, blank}, 32'h0);
    chk("rr_upd_count", n_upd - base, 4);
  endtask

  task automatic test_toggle();
    int base;
    base = n_upd;
    for (int t = 0; t < 10; t++) begin
      set_bus(4'b0100, (t % 2) ? pat_of(8) : pat_of(3));
      wait_ticks(1);
    end
    set_bus(4'b0, 7'b0);
    wait_ticks(1);
    chk("toggle_value", {28'b0, value[11:8]}, 32'h3);
    chk("toggle_no_upd", n_upd - base, 0);
  endtask

  task automatic test_bad_pattern();
    int base;
    base = n_errpat;
    set_bus(4'b0010, 7'b1010101);
    wait_ticks(2);
    chk("badpat_early", {31'b0, err_pat}, 32'h0);
    wait_ticks(1);
    chk("badpat_pulse", {31'b0, err_pat}, 32'h1);
    wait_ticks(3);
    set_bus(4'b0, 7'b0);
    chk("badpat_count", n_errpat - base, 1);
    chk("badpat_value", {16'b0, value}, 32'h4321);
    chk("badpat_blank", {28'b0, blank}, 32'h0);
  endtask

  task automatic test_multi_an();
    int base;
    base = n_erran;
    set_bus(4'b1000, pat_of(8));
    wait_ticks(2);
    set_bus(4'b0011, pat_of(8));
    wait_ticks(1);
    chk("multi_an_0011", {30'b0, err_an, upd}, 32'h2);
    set_bus(4'b1001, pat_of(8));
    wait_ticks(1);
    chk("multi_an_1001", {30'b0, err_an, upd}, 32'h2);
    // Digit 3 still at two stable samples, so one more commits it.
    set_bus(4'b1000, pat_of(8));
    push(3, 4'h8, 1'b0);
    wait_ticks(1);
    chk("multi_an_commit", {29'b0, upd, upd_idx[1:0]}, 32'h7);
    chk("multi_an_count", n_erran - base, 2);
    set_bus(4'b0, 7'b0);
  endtask

  task automatic test_reset_mid();
    wait_ticks(1);
    set_bus(4'b0100, pat_of(15));
    wait_ticks(2);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_reset_value", {16'b0, value}, 32'h0);
    chk("mid_reset_blank", {28'b0, blank}, 32'hF);
    push(2, 4'hF, 1'b0);
    wait_ticks(2);
    chk("mid_reset_no_upd", {31'b0, upd}, 32'h0);
    wait_ticks(1);
    chk("mid_reset_recommit", {29'b0, upd, upd_idx[1:0]}, 32'h6);
    set_bus(4'b0, 7'b0);
    wait_ticks(1);
  endtask

  initial begin
    rst = 1;
    set_bus(4'b0, 7'b0);
    test_reset();
    test_single();
    test_roundrobin();
    test_toggle();
    test_bad_pattern();
    test_multi_an();
    test_reset_mid();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
